sccb_init_seq: RTL and testbench



---
 rtl/cam_cfg_pkg.sv | 19 +
 rtl/ov2640_init_rom.sv | 20 ++
 rtl/sccb_init_seq.sv | 196 +++++++++++++++++++
 tb/tb_sccb_init_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cam_cfg_pkg.sv
// cam_cfg_pkg: shared sequencer states, ROM word layout and SCCB encodings.
package cam_cfg_pkg;
  typedef enum logic [3:0] {
    IDLE, RST_LOW, PWR_WAIT, FETCH, WRITE, DELAY, NEXT, DONE, ERR, VRD_ISSUE
  } state_t;
  typedef struct packed {
    logic       is_delay;
    logic [7:0] addr;
    logic [7:0] data;
  } rom_word_t;
  localparam int unsigned ROM_W = $bits(rom_word_t);
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ = 1'b1;
  localparam logic [7:0] DEV_ID_OV2640 = 8'h60;
  localparam logic [7:0] BANK_SEL_REG = 8'hFF;
  function automatic rom_word_t rom_entry(input logic dly, input logic [7:0] a, input logic [7:0] d);
    return '{is_delay: dly, addr: a, data: d};
  endfunction
endpackage

// File: rtl/ov2640_init_rom.sv
// ov2640_init_rom: combinational register table; indices past TABLE_LEN read as zero-length delays.
module ov2640_init_rom
  import cam_cfg_pkg::*;
#(
  parameter int unsigned TABLE_LEN = 64
) (
  input  logic [7:0] idx_i,
  output rom_word_t  word_o
);
  rom_word_t tbl;
  always_comb begin
    case (idx_i)
      8'd0:    tbl = rom_entry(1'b0, 8'hFF, 8'h01);
      8'd1:    tbl = rom_entry(1'b1, 8'h00, 8'h02);
      8'd2:    tbl = rom_entry(1'b0, 8'h12, 8'h80);
      default: tbl = rom_entry(1'b1, 8'h00, 8'h00);
    endcase
  end
  assign word_o = (32'(idx_i) < TABLE_LEN) ? tbl : rom_entry(1'b1, 8'h00, 8'h00);
endmodule

// File: rtl/sccb_init_seq.sv
// sccb_init_seq: camera reset/power-up then ROM-driven SCCB writes and ms delays.
// Define SCCB_INIT_VERIFY_EN to read back each write and retry on mismatch.
module sccb_init_seq
  import cam_cfg_pkg::*;
#(
  parameter int unsigned XCLK_FREQ   = 50_000_000,
  parameter logic [7:0]  DEV_ID      = DEV_ID_OV2640,
  parameter int unsigned TABLE_LEN   = 64,
  parameter int unsigned RST_HOLD_MS = 10,
  parameter int unsigned PWRUP_MS    = 20,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       XCLK,
  input  logic       RST,
  input  logic       start,
  output logic       busy,
  output logic       init_done,
  output logic       init_err,
  output logic [7:0] err_index,
  output logic       cam_rst_n,
  output logic       cam_pwdn,
  output logic       sccb_req,
  output logic       sccb_rw,
  output logic [7:0] sccb_id,
  output logic [7:0] sccb_reg,
  output logic [7:0] sccb_wdata,
  input  logic       sccb_done,
  input  logic [7:0] sccb_rdata
);
  localparam int unsigned TICK = XCLK_FREQ / 1000;
  localparam int CW = $clog2(TICK + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] ms_q, ms_d, ms_tgt;
  logic [7:0] idx_q, idx_d, id_q, id_d, reg_q, reg_d, wdata_q, wdata_d;
  logic busy_q, busy_d, done_q, done_d, rst_n_q, rst_n_d, req_q, req_d, rw_q, rw_d;
  logic tick_last, expire, timed, sccb_ev;
  rom_word_t word;
  ov2640_init_rom #(.TABLE_LEN(TABLE_LEN)) u_rom (.idx_i(idx_q), .word_o(word));
  assign ms_tgt = state_q == RST_LOW ? 16'(RST_HOLD_MS) : state_q == PWR_WAIT ? 16'(PWRUP_MS) : {8'd0, word.data};
  assign tick_last = cnt_q == CW'(TICK - 1);
  assign expire = ms_tgt == 16'd0 || (tick_last && ms_q == ms_tgt - 16'd1);
  assign timed = (state_q == RST_LOW || state_q == PWR_WAIT || state_q == DELAY) && !expire;
  assign cnt_d = timed ? (tick_last ? '0 : cnt_q + CW'(1)) : '0;
  assign ms_d = timed ? ms_q + 16'(tick_last) : '0;
  // a done pulse only counts while a request is outstanding
  assign sccb_ev = sccb_done & req_q;
`ifdef SCCB_INIT_VERIFY_EN
  logic err_q, err_d;
  logic [7:0] eidx_q, eidx_d, try_q, try_d;
  assign init_err = err_q;
  assign err_index = eidx_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^{sccb_rdata, 32'(MAX_RETRY)};
  assign init_err = 1'b0;
  assign err_index = 8'd0;
`endif
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    busy_d = busy_q;
    done_d = done_q;
    rst_n_d = rst_n_q;
    req_d = req_q;
    rw_d = rw_q;
    id_d = id_q;
    reg_d = reg_q;
    wdata_d = wdata_q;
`ifdef SCCB_INIT_VERIFY_EN
    err_d = err_q;
    eidx_d = eidx_q;
    try_d = try_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = RST_LOW;
        busy_d = 1'b1;
        done_d = 1'b0;
        rst_n_d = 1'b0;
`ifdef SCCB_INIT_VERIFY_EN
        err_d = 1'b0;
        eidx_d = 8'd0;
`endif
      end
      RST_LOW: if (expire) begin
        state_d = PWR_WAIT;
        rst_n_d = 1'b1;
      end
      PWR_WAIT: if (expire) begin
        state_d = FETCH;
        idx_d = 8'd0;
      end
      FETCH: begin
        state_d = word.is_delay ? DELAY : WRITE;
`ifdef SCCB_INIT_VERIFY_EN
        try_d = 8'd0;
`endif
      end
      WRITE: if (sccb_ev) begin
        req_d = 1'b0;
`ifdef SCCB_INIT_VERIFY_EN
        state_d = word.addr == BANK_SEL_REG ? NEXT : VRD_ISSUE;
`else
        state_d = NEXT;
`endif
      end else begin
        req_d = 1'b1;
        rw_d = RW_WRITE;
        id_d = DEV_ID;
        reg_d = word.addr;
        wdata_d = word.data;
      end
`ifdef SCCB_INIT_VERIFY_EN
      VRD_ISSUE: if (sccb_ev) begin
        req_d = 1'b0;
        try_d = try_q + 8'd1;
        state_d = sccb_rdata == word.data ? NEXT : try_q == 8'(MAX_RETRY) ? ERR : WRITE;
      end else begin
        req_d = 1'b1;
        rw_d = RW_READ;
        id_d = DEV_ID | 8'h01;
        reg_d = word.addr;
      end
      ERR: begin
        state_d = IDLE;
        err_d = 1'b1;
        eidx_d = idx_q;
        busy_d = 1'b0;
      end
`endif
      DELAY: if (expire) state_d = NEXT;
      NEXT: begin
        state_d = 32'(idx_q) == TABLE_LEN - 1 ? DONE : FETCH;
        idx_d = 32'(idx_q) == TABLE_LEN - 1 ? idx_q : idx_q + 8'd1;
      end
      DONE: begin
        state_d = IDLE;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge XCLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ms_q <= '0;
      idx_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rst_n_q <= 1'b1;
      req_q <= 1'b0;
      rw_q <= RW_WRITE;
      id_q <= DEV_ID;
      reg_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ms_q <= ms_d;
      idx_q <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rst_n_q <= rst_n_d;
      req_q <= req_d;
      rw_q <= rw_d;
      id_q <= id_d;
      reg_q <= reg_d;
      wdata_q <= wdata_d;
    end
  end
`ifdef SCCB_INIT_VERIFY_EN
  always_ff @(posedge XCLK or negedge RST) begin
    if (!RST) begin
      err_q <= 1'b0;
      eidx_q <= '0;
      try_q <= '0;
    end else begin
      err_q <= err_d;
      eidx_q <= eidx_d;
      try_q <= try_d;
    end
  end
`endif
  assign busy = busy_q;
  assign init_done = done_q;
  assign cam_rst_n = rst_n_q;
  assign cam_pwdn = 1'b0;
  assign sccb_req = req_q;
  assign sccb_rw = rw_q;
  assign sccb_id = id_q;
  assign sccb_reg = reg_q;
  assign sccb_wdata = wdata_q;
endmodule

// File: tb/tb_sccb_init_seq.sv
// tb_sccb_init_seq: directed checks of reset, table walk, delays, busy-start, mid-run reset.
// Verify-path steps run only when SCCB_INIT_VERIFY_EN is defined.
module tb_sccb_init_seq;
  localparam int TICK = 200;
  logic clk = 1'b0, rst_n, start, sccb_done, bad;
  logic busy, init_done, init_err, cam_rst_n, cam_pwdn, sccb_req, sccb_rw;
  logic [7:0] err_index, sccb_id, sccb_reg, sccb_wdata, sccb_rdata;
  int checks = 0, errors = 0, mcnt = 0, w12 = 0, r12 = 0, w0, r0, n;

  sccb_init_seq #(.XCLK_FREQ(TICK * 1000), .DEV_ID(8'h60), .TABLE_LEN(3),
                  .RST_HOLD_MS(10), .PWRUP_MS(20), .MAX_RETRY(3)) dut (
    .XCLK(clk), .RST(rst_n), .start(start), .busy(busy), .init_done(init_done),
    .init_err(init_err), .err_index(err_index), .cam_rst_n(cam_rst_n), .cam_pwdn(cam_pwdn),
    .sccb_req(sccb_req), .sccb_rw(sccb_rw), .sccb_id(sccb_id), .sccb_reg(sccb_reg),
    .sccb_wdata(sccb_wdata), .sccb_done(sccb_done), .sccb_rdata(sccb_rdata));

  always #5 clk = ~clk;

  // SCCB master model: done 50 cycles after req; reads of reg 12 return 80, or 00 when bad
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 0;
      sccb_done <= 1'b0;
    end else begin
      sccb_done <= 1'b0;
      if (sccb_req && !sccb_done) begin
        if (mcnt == 49) begin
          mcnt <= 0;
          sccb_done <= 1'b1;
          sccb_rdata <= bad ? 8'h00 : 8'h80;
          if (sccb_reg == 8'h12 && sccb_rw) r12 <= r12 + 1;
          if (sccb_reg == 8'h12 && !sccb_rw) w12 <= w12 + 1;
        end else mcnt <= mcnt + 1;
      end else mcnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_req(input logic lvl, input int lim, output int cnt);
    cnt = 0;
    while (sccb_req !== lvl && cnt < lim) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic wait_fin(input int lim, output int cnt);
    cnt = 0;
    while (!(init_done || init_err) && cnt < lim) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bad = 1'b0;
    sccb_rdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", init_done, 1'b0);
    chk("rst_err", init_err, 1'b0);
    chk("rst_eidx", err_index, 8'h00);
    chk("rst_camrst", cam_rst_n, 1'b1);
    chk("rst_pwdn", cam_pwdn, 1'b0);
    chk("rst_req", sccb_req, 1'b0);
    chk("rst_rw", sccb_rw, 1'b0);
    chk("rst_id", sccb_id, 8'h60);
    chk("rst_reg", sccb_reg, 8'h00);
    chk("rst_wdata", sccb_wdata, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    w0 = w12;
    r0 = r12;
    pulse_start();
    chk("start_busy", busy, 1'b1);
    chk("start_camrst", cam_rst_n, 1'b0);
    n = 0;
    while (!cam_rst_n && n < 30 * TICK) begin
      n++;
      @(negedge clk);
    end
    chk_rng("rst_low_len", n, 10 * TICK - 1, 10 * TICK + 1);
    n = 0;
    while (!sccb_req && n < 40 * TICK) begin
      start = (n == 1000);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk_rng("pwr_wait_len", n, 20 * TICK - 1, 20 * TICK + 3);
    chk("w1_reg", sccb_reg, 8'hFF);
    chk("w1_wdata", sccb_wdata, 8'h01);
    chk("w1_rw", sccb_rw, 1'b0);
    chk("w1_id", sccb_id, 8'h60);
    wait_req(1'b0, 200, n);
    chk_rng("w1_req_len", n, 50, 52);
    wait_req(1'b1, 4 * TICK, n);
    chk_rng("delay_gap", n, 2 * TICK, 2 * TICK + 6);
    chk("w2_reg", sccb_reg, 8'h12);
    chk("w2_wdata", sccb_wdata, 8'h80);
    chk("w2_rw", sccb_rw, 1'b0);
    chk("w2_id", sccb_id, 8'h60);
`ifdef SCCB_INIT_VERIFY_EN
    wait_req(1'b0, 200, n);
    wait_req(1'b1, 20, n);
    chk_rng("rd_gap", n, 1, 4);
    chk("rd_rw", sccb_rw, 1'b1);
    chk("rd_id", sccb_id, 8'h61);
    chk("rd_reg", sccb_reg, 8'h12);
`endif
    wait_fin(1000, n);
    chk_rng("fin_timeout", n, 0, 999);
    chk("fin_done", init_done, 1'b1);
    chk("fin_busy", busy, 1'b0);
    chk("fin_err", init_err, 1'b0);
    chk("fin_w12", 32'(w12 - w0), 32'd1);
`ifdef SCCB_INIT_VERIFY_EN
    chk("fin_r12", 32'(r12 - r0), 32'd1);
    bad = 1'b1;
    w0 = w12;
    r0 = r12;
    pulse_start();
    chk("vf_done_clr", init_done, 1'b0);
    wait_fin(60 * TICK, n);
    chk_rng("vf_timeout", n, 0, 60 * TICK - 1);
    chk("vf_err", init_err, 1'b1);
    chk("vf_done", init_done, 1'b0);
    chk("vf_eidx", err_index, 8'd2);
    chk("vf_busy", busy, 1'b0);
    chk("vf_w12", 32'(w12 - w0), 32'd4);
    chk("vf_r12", 32'(r12 - r0), 32'd4);
    bad = 1'b0;
`else
    chk("fin_r12", 32'(r12 - r0), 32'd0);
`endif
    pulse_start();
    n = 0;
    while (!(sccb_req && sccb_reg == 8'h12) && n < 60 * TICK) begin
      n++;
      @(negedge clk);
    end
    chk_rng("e2_timeout", n, 0, 60 * TICK - 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", sccb_req, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_camrst", cam_rst_n, 1'b1);
    chk("ar_reg", sccb_reg, 8'h00);
    chk("ar_wdata", sccb_wdata, 8'h00);
    chk("ar_id", sccb_id, 8'h60);
    chk("ar_done", init_done, 1'b0);
    chk("ar_err", init_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    wait_req(1'b1, 40 * TICK, n);
    chk_rng("replay_timeout", n, 0, 40 * TICK - 1);
    chk("replay_reg", sccb_reg, 8'hFF);
    chk("replay_wdata", sccb_wdata, 8'h01);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
